// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file completer: FSM state codes,
// the default ID word and a helper for the byte-offset width.
package apb_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

    localparam logic [31:0] ID_VALUE_DEF = 32'hA9B0_0001;

    // Number of PADDR bits that select a byte within one data word.
    function automatic int bpw_lg2(input int dwidth);
        return $clog2(dwidth / 8);
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// NREGS x DWIDTH register storage. Word 0 is a hardwired ID constant; the
// remaining words take byte-strobed writes. Reads are a plain mux.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int              DWIDTH   = 32,
    parameter int              NREGS    = 8,
    parameter int              IW       = 3,
    parameter logic [DWIDTH-1:0] ID_VALUE = DWIDTH'(ID_VALUE_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IW-1:0]       widx,
    input  logic [DWIDTH-1:0]   wdata,
    input  logic [DWIDTH/8-1:0] wstrb,
    input  logic [IW-1:0]       ridx,
    output logic [DWIDTH-1:0]   rdata
);

    localparam int BPW   = DWIDTH / 8;
    localparam int DEPTH = 1 << IW;

    // Padded to a power of two so the read mux never indexes past the end;
    // the padding words read as zero (the decoder flags those as errors).
    logic [DWIDTH-1:0] words [DEPTH];

    assign words[0] = ID_VALUE;

    for (genvar w = 1; w < NREGS; w++) begin : g_word
        logic [DWIDTH-1:0] q;

        // Byte-lane update of one writable word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (we && widx == IW'(w)) begin
                for (int b = 0; b < BPW; b++) begin
                    if (wstrb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end

        assign words[w] = q;
    end

    for (genvar w = NREGS; w < DEPTH; w++) begin : g_pad
        assign words[w] = '0;
    end

    assign rdata = words[ridx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer in front of a small register bank. Captures the transfer in
// the setup cycle, stalls the access phase for WAIT_CYCLES cycles, then
// returns a registered one-cycle response. Writes commit on the completing edge.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                DWIDTH      = 32,
    parameter int                AWIDTH      = 32,
    parameter int                NREGS       = 8,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DWIDTH-1:0] ID_VALUE    = DWIDTH'(ID_VALUE_DEF)
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [AWIDTH-1:0]   PADDR,
    input  logic [DWIDTH-1:0]   PWDATA,
    input  logic [DWIDTH/8-1:0] PSTRB,
    output logic                PREADY,
    output logic [DWIDTH-1:0]   PRDATA,
    output logic                PSLVERR
);

    localparam int BPW = DWIDTH / 8;
    localparam int LG  = bpw_lg2(DWIDTH);
    localparam int IW  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [AWIDTH:0] LIMIT = (AWIDTH + 1)'(NREGS * BPW);

    typedef struct packed {
        logic              write;
        logic              err;
        logic [IW-1:0]     idx;
        logic [DWIDTH-1:0] wdata;
        logic [BPW-1:0]    strb;
    } req_t;

    logic [1:0]        state;
    logic [3:0]        cnt;
    req_t              req;

    logic              misalign, oor, err_in;
    logic [IW-1:0]     idx_in;
    logic [IW-1:0]     bank_ridx;
    logic [DWIDTH-1:0] bank_rdata;
    logic              cur_write, cur_err;
    logic [DWIDTH-1:0] resp_rdata;
    logic              bank_we;

    // Address decode of the live bus (only meaningful in the setup cycle).
    assign misalign = |(PADDR & AWIDTH'(BPW - 1));
    assign oor      = {1'b0, PADDR} >= LIMIT;
    assign idx_in   = PADDR[LG +: IW];
    assign err_in   = misalign | oor | (PWRITE && idx_in == '0);

    // With no wait states the response is registered straight from the
    // setup cycle, so the read port follows the live bus while idle and the
    // captured request otherwise.
    assign bank_ridx  = (state == ST_IDLE) ? idx_in  : req.idx;
    assign cur_write  = (state == ST_IDLE) ? PWRITE  : req.write;
    assign cur_err    = (state == ST_IDLE) ? err_in  : req.err;
    assign resp_rdata = (cur_write || cur_err) ? '0 : bank_rdata;

    assign bank_we = (state == ST_RESP) && req.write && !req.err;

    apb_reg_bank #(
        .DWIDTH   (DWIDTH),
        .NREGS    (NREGS),
        .IW       (IW),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (bank_we),
        .widx  (req.idx),
        .wdata (req.wdata),
        .wstrb (req.strb),
        .ridx  (bank_ridx),
        .rdata (bank_rdata)
    );

    // Transfer FSM, wait counter and registered response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            req     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                    if (PSEL && !PENABLE) begin
                        req <= '{write: PWRITE, err: err_in, idx: idx_in,
                                 wdata: PWDATA, strb: PSTRB};
                        if (WAIT_CYCLES == 0) begin
                            state   <= ST_RESP;
                            PREADY  <= 1'b1;
                            PSLVERR <= err_in;
                            PRDATA  <= resp_rdata;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        // Master abandoned the transfer; the write is dropped.
                        state <= ST_IDLE;
                    end else if (PENABLE) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= ST_RESP;
                            PREADY  <= 1'b1;
                            PSLVERR <= req.err;
                            PRDATA  <= resp_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    PRDATA  <= '0;
                end
            endcase
        end
    end

endmodule
